// File: rtl/im_loader.sv
// Byte-stream loader for instruction memory: a header byte, a 16-bit word count, then
// three bytes per 17-bit instruction. The CPU is stalled while a load is in progress.
module im_loader #(
   parameter int unsigned DEPTH   = 2048,
   parameter logic [7:0]  HDR     = 8'hA5,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_vld,
   input  logic [7:0]  byte_data,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rd_en,
   output logic [15:0] im_addr,
   output logic        im_rd_en,
   output logic        im_we,
   output logic [16:0] im_wdata,
   output logic        cpu_stall,
   output logic        done,
   output logic        err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CNT_HI = 3'd1;
   localparam logic [2:0] CNT_LO = 3'd2;
   localparam logic [2:0] B0     = 3'd3;
   localparam logic [2:0] B1     = 3'd4;
   localparam logic [2:0] B2     = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;
   localparam logic [2:0] ERR    = 3'd7;

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [15:0]   wr_addr;
   logic [15:0]   count;
   logic [7:0]    cnt_hi;
   logic          instr_msb;
   logic [7:0]    instr_mid;
   logic [TW-1:0] idle_cnt;

   logic          loading;
   logic [15:0]   count_in;
   logic          count_bad;
   logic          last_word;
   logic          timeout_hit;

   assign loading     = (state == CNT_HI) || (state == CNT_LO) || (state == B0) ||
                        (state == B1) || (state == B2);
   assign count_in    = {cnt_hi, byte_data};
   assign count_bad   = (count_in == 16'd0) || (32'(count_in) > 32'(DEPTH));
   // wr_addr has already advanced past the previous word by the time a B2 byte can arrive
   assign last_word   = (wr_addr == (count - 16'd1));
   assign timeout_hit = loading && !byte_vld && (idle_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (byte_vld && (byte_data == HDR)) state_nxt = CNT_HI;
         CNT_HI:          if (byte_vld) state_nxt = CNT_LO;
         CNT_LO:          if (byte_vld) state_nxt = count_bad ? ERR : B0;
         B0:              if (byte_vld) state_nxt = B1;
         B1:              if (byte_vld) state_nxt = B2;
         B2:              if (byte_vld) state_nxt = last_word ? DONE : B0;
         default:         state_nxt = IDLE;
      endcase
      if (timeout_hit) state_nxt = ERR;
   end

   // Byte capture, word assembly, write strobe and inter-byte idle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr   <= 16'd0;
         count     <= 16'd0;
         cnt_hi    <= 8'd0;
         instr_msb <= 1'b0;
         instr_mid <= 8'd0;
         idle_cnt  <= '0;
         im_we     <= 1'b0;
         im_wdata  <= 17'd0;
      end else begin
         im_we <= 1'b0;
         if (im_we) wr_addr <= wr_addr + 16'd1;

         if (loading) idle_cnt <= byte_vld ? '0 : idle_cnt + TW'(1);
         else         idle_cnt <= '0;

         if (byte_vld) begin
            case (state)
               CNT_HI: cnt_hi <= byte_data;
               CNT_LO: begin
                  count   <= count_in;
                  wr_addr <= 16'd0;
               end
               B0:     instr_msb <= byte_data[0];
               B1:     instr_mid <= byte_data;
               B2: begin
                  im_we    <= 1'b1;
                  im_wdata <= {instr_msb, instr_mid, byte_data};
               end
               default: ;
            endcase
         end
      end
   end

   // The final word's strobe lands in the first DONE cycle, so the write port keeps
   // priority over CPU fetches for that one cycle.
   assign cpu_stall = loading;
   assign done      = (state == DONE);
   assign err       = (state == ERR);
   assign im_addr   = (loading || im_we) ? wr_addr : cpu_addr;
   assign im_rd_en  = cpu_rd_en && !loading && !im_we;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader; expected memory writes are queued as bytes are sent and
// checked by a monitor as each im_we pulse appears.
module tb_im_loader;

   localparam int unsigned TO = 40;

   logic        clk;
   logic        rst;
   logic        byte_vld;
   logic [7:0]  byte_data;
   logic [15:0] cpu_addr;
   logic        cpu_rd_en;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic        im_we;
   logic [16:0] im_wdata;
   logic        cpu_stall;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [15:0] addr;
      logic [16:0] data;
   } wr_t;

   wr_t q[$];
   int  total = 0;
   int  bad   = 0;
   int  wr_seen = 0;

   im_loader #(.DEPTH(2048), .HDR(8'hA5), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .byte_vld(byte_vld), .byte_data(byte_data),
      .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en), .im_addr(im_addr),
      .im_rd_en(im_rd_en), .im_we(im_we), .im_wdata(im_wdata),
      .cpu_stall(cpu_stall), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      byte_data = b;
      byte_vld  = 1'b1;
      @(posedge clk);
      #1 byte_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [16:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      q.push_back(w);
   endtask

   // Scoreboard monitor: every strobe must match the oldest queued write; no fetch while stalled
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         wr_seen++;
         if (q.size() == 0) chk("unexpected_we", 32'(im_addr), 32'hFFFF_FFFF);
         else begin
            wr_t w;
            w = q.pop_front();
            chk("we_addr", 32'(im_addr), 32'(w.addr));
            chk("we_data", 32'(im_wdata), 32'(w.data));
         end
      end
      if (cpu_stall === 1'b1) chk("rd_en_during_stall", 32'(im_rd_en), 32'd0);
   end

   initial begin
      int base;
      rst       = 1'b1;
      byte_vld  = 1'b0;
      byte_data = 8'h00;
      cpu_addr  = 16'h1234;
      cpu_rd_en = 1'b1;
      idle(2);
      chk("rst_we", 32'(im_we), 32'd0);
      chk("rst_wdata", 32'(im_wdata), 32'd0);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_addr", 32'(im_addr), 32'h1234);
      chk("rst_rd_en", 32'(im_rd_en), 32'd1);
      rst = 1'b0;
      idle(1);

      // Two-word load
      base = wr_seen;
      expect_wr(16'd0, 17'h12345);
      expect_wr(16'd1, 17'h0ABCD);
      send(8'hA5);
      chk("load_stall", 32'(cpu_stall), 32'd1);
      send(8'h00); send(8'h02);
      chk("load_addr", 32'(im_addr), 32'd0);
      send(8'h01); send(8'h23); send(8'h45);
      send(8'h00); send(8'hAB); send(8'hCD);
      idle(2);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_err", 32'(err), 32'd0);
      chk("t1_stall", 32'(cpu_stall), 32'd0);
      chk("t1_addr", 32'(im_addr), 32'h1234);
      chk("t1_writes", 32'(wr_seen - base), 32'd2);

      // Zero count aborts, then a one-word load recovers
      base = wr_seen;
      send(8'hA5); send(8'h00); send(8'h00);
      idle(1);
      chk("t2_err", 32'(err), 32'd1);
      chk("t2_done", 32'(done), 32'd0);
      chk("t2_writes", 32'(wr_seen - base), 32'd0);
      expect_wr(16'd0, 17'h00007);
      send(8'hA5);
      chk("t2_err_clr", 32'(err), 32'd0);
      send(8'h00); send(8'h01); send(8'h00); send(8'h00); send(8'h07);
      idle(2);
      chk("t2_done2", 32'(done), 32'd1);
      chk("t2_err2", 32'(err), 32'd0);
      chk("t2_writes2", 32'(wr_seen - base), 32'd1);

      // Count 2049 exceeds DEPTH
      base = wr_seen;
      send(8'hA5); send(8'h08); send(8'h01);
      idle(1);
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_stall", 32'(cpu_stall), 32'd0);
      chk("t3_writes", 32'(wr_seen - base), 32'd0);

      // Inter-byte timeout: ERR on exactly the TIMEOUT-th idle cycle
      base = wr_seen;
      send(8'hA5); send(8'h00); send(8'h01); send(8'h01);
      idle(TO - 1);
      chk("t4_stall_pre", 32'(cpu_stall), 32'd1);
      chk("t4_err_pre", 32'(err), 32'd0);
      idle(1);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_stall", 32'(cpu_stall), 32'd0);
      chk("t4_writes", 32'(wr_seen - base), 32'd0);

      // Back-to-back three-word load; an HDR value inside the payload is plain data
      base = wr_seen;
      expect_wr(16'd0, 17'h1A5A5);
      expect_wr(16'd1, 17'h00001);
      expect_wr(16'd2, 17'h01234);
      send(8'hA5); send(8'h00); send(8'h03);
      send(8'h01); send(8'hA5); send(8'hA5);
      send(8'h00); send(8'h00); send(8'h01);
      send(8'hFE); send(8'h12); send(8'h34);
      idle(2);
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_writes", 32'(wr_seen - base), 32'd3);
      chk("t5_rd_en", 32'(im_rd_en), 32'd1);

      // Reset mid-load, after B1 of the first word
      base = wr_seen;
      cpu_addr = 16'h0BEE;
      send(8'hA5); send(8'h00); send(8'h02); send(8'h00); send(8'h11);
      rst = 1'b1;
      #1;
      chk("t6_stall", 32'(cpu_stall), 32'd0);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      chk("t6_we", 32'(im_we), 32'd0);
      chk("t6_addr", 32'(im_addr), 32'h0BEE);
      idle(2);
      rst = 1'b0;
      send(8'h22);
      idle(3);
      chk("t6_stall_after", 32'(cpu_stall), 32'd0);
      chk("t6_writes", 32'(wr_seen - base), 32'd0);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter: DEPTH, 2048, instruction-memory words; legal word count 1..DEPTH.
REQ-002 Parameter: HDR, 8'hA5, load-start header byte.
REQ-003 Parameter: TIMEOUT, 50000, maximum clk cycles between bytes during a load.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 byte_vld  in  1  one-cycle strobe; byte_data valid.
REQ-007 byte_data  in  8  received byte (UART/SPI side).
REQ-008 cpu_addr  in  16  CPU fetch address.
REQ-009 cpu_rd_en  in  1  CPU fetch request.
REQ-010 im_addr  out  16  address to instruction memory.
REQ-011 im_rd_en  out  1  read enable to instruction memory.
REQ-012 im_we  out  1  one-cycle write strobe to instruction memory.
REQ-013 im_wdata  out  17  write data to instruction memory.
REQ-014 cpu_stall  out  1  high while a load is in progress.
REQ-015 done  out  1  last load completed successfully.
REQ-016 err  out  1  last load aborted.

Function
REQ-017 The FSM SHALL have states IDLE, CNT_HI, CNT_LO, B0, B1, B2, DONE and ERR.
REQ-018 IDLE/DONE/ERR: a byte equal to HDR SHALL move the FSM to CNT_HI and clear done and err; other bytes SHALL be ignored.
REQ-019 CNT_HI then CNT_LO SHALL capture a 16-bit word count, MSB byte first.
REQ-020 Count 0 or count > DEPTH SHALL move the FSM to ERR on the CNT_LO byte; otherwise the FSM SHALL move to B0 with the write address cleared to 0.
REQ-021 B0 SHALL capture byte_data[0] as instr[16] (bits 7:1 ignored), B1 instr[15:8], B2 instr[7:0].
REQ-022 On the B2 byte, im_we SHALL pulse high on the next cycle with im_wdata = assembled word and im_addr = current write address.
REQ-023 The write address SHALL increment by 1 in the cycle after each im_we pulse.
REQ-024 After the B2 byte of word count-1, the FSM SHALL go to DONE; otherwise it SHALL go to B0.
REQ-025 A byte on the cycle immediately after B2 SHALL be accepted as the next B0 byte (no lost bytes, no extra states).
REQ-026 While in CNT_HI..B2, an idle-cycle counter SHALL reset on each byte_vld; reaching TIMEOUT SHALL move the FSM to ERR.
REQ-027 cpu_stall SHALL be high in CNT_HI, CNT_LO, B0, B1, B2 and low otherwise.
REQ-028 While cpu_stall is high, im_rd_en SHALL be 0 and im_addr SHALL equal the write address.
REQ-029 While cpu_stall is low, im_addr SHALL equal cpu_addr and im_rd_en SHALL equal cpu_rd_en, combinationally.
REQ-030 done SHALL be high only in DONE; err only in ERR.
REQ-031 In ERR, memory contents already written SHALL remain; no further im_we until a new load.
REQ-032 A HDR byte during CNT_HI..B2 SHALL be treated as data, not as a restart.

Reset
REQ-033 rst SHALL force IDLE asynchronously, clear the write address, count, idle counter and assembly registers.
REQ-034 While rst is high: im_we=0, im_wdata=0, cpu_stall=0, done=0, err=0; im_addr/im_rd_en follow cpu_addr/cpu_rd_en.
REQ-035 rst mid-load SHALL abort without a trailing im_we pulse.

Verification
REQ-036 Bytes A5,00,02,01,23,45,00,AB,CD -> im_we at addr 0 data 17'h12345, addr 1 data 17'h0ABCD; done=1; cpu_stall low after.
REQ-037 Bytes A5,00,00 -> err=1, no im_we; then A5,00,01,00,00,07 -> err=0, write addr 0 data 17'h00007, done=1.
REQ-038 Bytes A5,08,01 (2049 > DEPTH) -> err=1, no im_we, cpu_stall=0.
REQ-039 A5,00,01,01 then no byte for TIMEOUT cycles -> err=1, no im_we, cpu_stall drops.
REQ-040 Back-to-back bytes every cycle, count 3 -> three im_we pulses at addr 0,1,2, none lost; cpu_rd_en=1 during load -> im_rd_en=0 throughout.
REQ-041 rst asserted after B1 of word 1 -> immediate IDLE, no im_we, done=err=0, im_addr = cpu_addr.
